// File: rtl/hyperram_responder.sv
// hyperram_responder
//   Device side of a HyperRAM link, backed by an internal byte array. It decodes a
//   6-byte command/address, waits a fixed initial latency, then either absorbs
//   write bytes (masked by RWDS) or returns read bytes with an RWDS strobe.
// Ports
//   clk, rst                       clock; asynchronous active-high reset
//   cs_bar                         chip select, active low; frames a transaction
//   dq_in / dq_out / dq_oe         DQ byte from controller / read data / pad enable
//   rwds_in / rwds_out / rwds_oe   write byte-enable / read strobe / pad enable
//   busy                           high whenever not idle
//   protocol_error                 sticky: cs_bar rose during CA or latency
module hyperram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_bar,
  input  logic [7:0] dq_in,
  output logic [7:0] dq_out,
  output logic       dq_oe,
  input  logic       rwds_in,
  output logic       rwds_out,
  output logic       rwds_oe,
  output logic       busy,
  output logic       protocol_error
);
  localparam int MEM_BYTES = 2**ADDR_WIDTH;
  localparam int LW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CA    = 3'd1;
  localparam logic [2:0] S_LAT   = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;

  logic [7:0]            mem [MEM_BYTES];
  logic [2:0]            state_q, state_d;
  logic [47:0]           ca_q, ca_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_q, rd_d, reg_q, reg_d;
  logic [7:0]            dq_out_q, dq_out_d;
  logic                  dq_oe_q, dq_oe_d;
  logic                  rwds_out_q, rwds_out_d;
  logic                  rwds_oe_q, rwds_oe_d;
  logic                  err_q, err_d;

  logic [47:0] ca_shift;
  logic [23:0] start_byte;
  logic [7:0]  rd_byte;
  logic        mem_we;
  logic        ca_unused;

  // Full CA word as it will look once the current byte is shifted in.
  assign ca_shift   = {ca_q[39:0], dq_in};
  assign start_byte = {ca_shift[35:16], ca_shift[2:0], 1'b0};
  assign rd_byte    = reg_q ? 8'h00 : mem[addr_q];
  // Reserved CA fields and high address bits beyond the array are don't-care.
  assign ca_unused  = ^{ca_q, ca_shift, start_byte};

  always_comb begin
    state_d    = state_q;
    ca_d       = ca_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    reg_d      = reg_q;
    dq_out_d   = dq_out_q;
    dq_oe_d    = dq_oe_q;
    rwds_out_d = rwds_out_q;
    rwds_oe_d  = rwds_oe_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    case (state_q)
      S_IDLE: if (!cs_bar) begin
        ca_d    = {40'b0, dq_in};
        cnt_d   = 3'd1;
        state_d = S_CA;
      end
      S_CA: if (cs_bar) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        ca_d = ca_shift;
        if (cnt_q == 3'd5) begin
          state_d   = S_LAT;
          lat_d     = '0;
          rd_d      = ca_shift[47];
          reg_d     = ca_shift[46];
          addr_d    = start_byte[ADDR_WIDTH-1:0];
          rwds_oe_d = ca_shift[47];  // reads hold RWDS low through latency
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_LAT: if (cs_bar) begin
        state_d   = S_IDLE;
        err_d     = 1'b1;
        rwds_oe_d = 1'b0;
      end else if (lat_q == LW'(WAIT_CYCLES - 1)) begin
        state_d = rd_q ? S_RDATA : S_WDATA;
        if (rd_q) dq_out_d = rd_byte;
      end else begin
        lat_d = lat_q + LW'(1);
      end
      S_RDATA: if (cs_bar) begin
        state_d    = S_IDLE;
        dq_oe_d    = 1'b0;
        rwds_oe_d  = 1'b0;
        rwds_out_d = 1'b0;
      end else begin
        dq_out_d   = rd_byte;
        dq_oe_d    = 1'b1;
        rwds_oe_d  = 1'b1;
        rwds_out_d = 1'b1;
        addr_d     = addr_q + ADDR_WIDTH'(1);
      end
      S_WDATA: if (cs_bar) begin
        state_d = S_IDLE;
      end else begin
        mem_we = rwds_in & ~reg_q;
        addr_d = addr_q + ADDR_WIDTH'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ca_q       <= '0;
      cnt_q      <= '0;
      lat_q      <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      reg_q      <= 1'b0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      rwds_out_q <= 1'b0;
      rwds_oe_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ca_q       <= ca_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      reg_q      <= reg_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      rwds_out_q <= rwds_out_d;
      rwds_oe_q  <= rwds_oe_d;
      err_q      <= err_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= dq_in;
  end

  assign dq_out         = dq_out_q;
  assign dq_oe          = dq_oe_q;
  assign rwds_out       = rwds_out_q;
  assign rwds_oe        = rwds_oe_q;
  assign busy           = (state_q != S_IDLE);
  assign protocol_error = err_q;
endmodule
